// File: rtl/vec_load_unit.sv
// Vector load engine: fetches SEW-wide elements one at a time over a valid/ready port and
// assembles a masked, tail-filled register-group write for the vector register file.
module vec_load_unit #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned VLEN     = 512,
   parameter int unsigned MAX_VLEN = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [XLEN-1:0]     base_addr,
   input  logic [XLEN-1:0]     stride,
   input  logic                strided,
   input  logic [5:0]          sew,
   input  logic [XLEN-1:0]     vl,
   input  logic                vec_mask,
   input  logic                mask_agnostic,
   input  logic                tail_agnostic,
   input  logic [VLEN-1:0]     v0_mask_data,
   input  logic [MAX_VLEN-1:0] dst_vec_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [XLEN-1:0]     mem_addr,
   input  logic                mem_rsp_valid,
   input  logic [XLEN-1:0]     mem_rsp_data,
   output logic [MAX_VLEN-1:0] vec_wr_data,
   output logic                vec_wr_en,
   output logic                busy,
   output logic                done,
   output logic                error
);

   localparam int unsigned IW = $clog2(VLEN) + 1;
   localparam int unsigned BW = $clog2(MAX_VLEN);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StWb} state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     stride_q, vl_q;
   logic [5:0]          sew_q;
   logic                strided_q, vm_q, ma_q;
   logic [VLEN-1:0]     v0_q;
   logic [MAX_VLEN-1:0] buf_q, buf_d, wr_data_q;
   logic                done_q, done_d, error_q, error_d;
   logic                cfg_load, wb_load, advance, last_elem, elem_active, cfg_err;
   logic [XLEN-1:0]     max_elems, step;
   logic [MAX_VLEN-1:0] tail_mask;

   function automatic logic [MAX_VLEN-1:0] put_elem(input logic [MAX_VLEN-1:0] vec,
                                                    input logic [IW-1:0]       i,
                                                    input logic [5:0]          w,
                                                    input logic [XLEN-1:0]     val);
      logic [MAX_VLEN-1:0] r;
      r = vec;
      case (w)
         6'd8:    r[(BW'(i) << 3) +: 8]   = val[7:0];
         6'd16:   r[(BW'(i) << 4) +: 16]  = val[15:0];
         default: r[(BW'(i) << 5) +: 32]  = val[31:0];
      endcase
      return r;
   endfunction

   // Legality and tail region are judged on the raw inputs, since they are only used at start.
   always_comb begin
      case (sew)
         6'd8:    max_elems = XLEN'(MAX_VLEN / 8);
         6'd16:   max_elems = XLEN'(MAX_VLEN / 16);
         6'd32:   max_elems = XLEN'(MAX_VLEN / 32);
         default: max_elems = '0;
      endcase
      cfg_err   = (max_elems == '0) || (vl > max_elems);
      tail_mask = {MAX_VLEN{1'b1}} << (vl * XLEN'(sew));
   end

   assign elem_active = vm_q | v0_q[idx_q[IW-2:0]];
   assign last_elem   = (XLEN'(idx_q) + XLEN'(1)) == vl_q;
   assign step        = strided_q ? stride_q : XLEN'(sew_q[5:3]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      buf_d    = buf_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      cfg_load = 1'b0;
      advance  = 1'b0;
      wb_load  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cfg_load = 1'b1;
               idx_d    = '0;
               addr_d   = base_addr;
               if (cfg_err) begin
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else if (vl == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StReq;
                  // Pre-fill with old contents so undisturbed elements need no later write.
                  buf_d   = tail_agnostic ? (dst_vec_data | tail_mask) : dst_vec_data;
               end
            end
         end
         StReq: begin
            if (elem_active) begin
               if (mem_req_ready) state_d = StResp;
            end else begin
               if (ma_q) buf_d = put_elem(buf_q, idx_q, sew_q, '1);
               advance = 1'b1;
            end
         end
         StResp: begin
            if (mem_rsp_valid) begin
               buf_d   = put_elem(buf_q, idx_q, sew_q, mem_rsp_data);
               advance = 1'b1;
            end
         end
         StWb: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (advance) begin
         idx_d   = idx_q + 1'b1;
         addr_d  = addr_q + step;
         state_d = last_elem ? StWb : StReq;
         wb_load = last_elem;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q     <= '0;
         addr_q    <= '0;
         stride_q  <= '0;
         vl_q      <= '0;
         sew_q     <= '0;
         strided_q <= 1'b0;
         vm_q      <= 1'b0;
         ma_q      <= 1'b0;
         v0_q      <= '0;
         buf_q     <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         done_q  <= done_d;
         error_q <= error_d;
         if (cfg_load) begin
            stride_q  <= stride;
            vl_q      <= vl;
            sew_q     <= sew;
            strided_q <= strided;
            vm_q      <= vec_mask;
            ma_q      <= mask_agnostic;
            v0_q      <= v0_mask_data;
         end
         if (wb_load) wr_data_q <= buf_d;
      end
   end

   always_comb begin
      mem_req_valid = (state_q == StReq) && elem_active;
      mem_addr      = addr_q;
      busy          = (state_q != StIdle);
      vec_wr_en     = (state_q == StWb);
      done          = done_q | vec_wr_en;
      error         = error_q;
      vec_wr_data   = wr_data_q;
   end

endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Vector load engine that fetches elements from data memory and assembles them into one register-group write for the vector register file. It takes the base address and stride from the decoded scalar operands, and SEW and VL from the vector CSR file. It issues one element request at a time over a valid/ready memory port and applies v0 masking plus tail/mask-agnostic fill. It delivers the result as a single-cycle `vec_wr_en` pulse with a MAX_VLEN-wide `vec_wr_data`, and sits beside the vector datapath on the regfile write port.

## Interface
- `XLEN`, 32, scalar/address width
- `VLEN`, 512, single vector register width (v0 mask width)
- `MAX_VLEN`, 4096, register-group width (VLEN*8)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a load; sampled only in IDLE
- `base_addr`  in  XLEN  element 0 byte address (scalar1)
- `stride`  in  XLEN  byte stride (scalar2), used when `strided`=1
- `strided`  in  1  0: unit stride (SEW/8 bytes), 1: `stride`
- `sew`  in  6  element width in bits; legal values 8, 16, 32
- `vl`  in  XLEN  active element count
- `vec_mask`  in  1  0: masked by v0, 1: unmasked (RVV vm)
- `mask_agnostic`, `tail_agnostic`  in  1 each  fill policy
- `v0_mask_data`  in  VLEN  mask bits; bit i governs element i
- `dst_vec_data`  in  MAX_VLEN  old destination contents
- `mem_req_valid`  out  1;  `mem_req_ready`  in  1;  `mem_addr`  out  XLEN
- `mem_rsp_valid`  in  1;  `mem_rsp_data`  in  XLEN  element right-aligned
- `vec_wr_data`  out  MAX_VLEN;  `vec_wr_en`  out  1
- `busy`  out  1;  `done`  out  1;  `error`  out  1

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE + `start`: latch all inputs and set element index i=0 and addr=base_addr.
  - `sew` illegal, or `vl` > MAX_VLEN/sew: pulse `error` and `done` next cycle, stay IDLE, no write.
  - `vl`=0: pulse `done` next cycle, no write.
  - Otherwise go to REQ.
- REQ, element i active (`vec_mask`=1 or v0[i]=1): drive `mem_req_valid`=1 and `mem_addr`=addr.
  - On `mem_req_ready`, go to RESP.
  - `mem_addr` and `valid` hold stable until accepted.
- REQ, element i inactive: no request. The element is written with all-ones if `mask_agnostic`, otherwise with the `dst_vec_data` element. Advance in 1 cycle.
- RESP: on `mem_rsp_valid`, element i = `mem_rsp_data[sew-1:0]`, then advance. `mem_rsp_valid` is ignored outside RESP.
- Advance: i+=1; addr += SEW/8 (unit) or `stride` (strided), XLEN wrap-around modulo 2^XLEN. If i==vl go to WB, else go to REQ.
- WB: elements vl..MAX_VLEN/sew-1 become all-ones if `tail_agnostic`, otherwise the `dst_vec_data` bits. Assert `vec_wr_en` and `done` for one cycle, then go to IDLE.
- `busy`=1 in REQ, RESP and WB.
- `start` is ignored while busy.
- Element i occupies bits [i*sew +: sew].

## Timing
- Reset (async): state=IDLE. All outputs are 0, including `vec_wr_data` and the internal buffer. An in-flight load is abandoned with no write.
- `start` sampled at cycle 0 → REQ at cycle 1.
- Zero-wait memory (ready and rsp same cycle as asked): active element k is requested at cycle 1+2k.
- Each masked-off element costs 1 cycle.
- `vec_wr_en` rises at cycle 1 + 2·(active count) + (inactive count).
- `vec_wr_data` is valid only while `vec_wr_en`=1 and holds afterwards until the next write.
- Error and vl=0 responses: `done` (with `error` if applicable) at cycle 1.
- Only one outstanding request at a time; no new `mem_req_valid` while in RESP.

## Test plan
- Unit stride, sew=32, vl=4, base=0x100, unmasked, zero-wait memory returning 0xA0..0xA3 → addrs 0x100,0x104,0x108,0x10C; `vec_wr_en` at cycle 9; bits[127:0]=0x000000A3_000000A2_000000A1_000000A0; tail = `dst_vec_data` (tail_agnostic=0).
- Strided, sew=8, stride=0x10, vl=3, base=0xFFFFFFF0 → addrs 0xFFFFFFF0, 0x00000000, 0x00000010 (wrap); tail_agnostic=1 → bits above 23 all ones.
- Masked, sew=16, vl=4, v0=4'b0101, mask_agnostic=0 → requests only for elements 0 and 2; elements 1 and 3 equal `dst_vec_data`; `vec_wr_en` at cycle 7.
- Back-pressure: `mem_req_ready` low for 3 cycles → `mem_addr` stable and `mem_req_valid` held; `start` pulsed mid-load is ignored.
- sew=64 or vl=200 with sew=32 → `error`+`done` at cycle 1, no `vec_wr_en`; vl=0 → `done` only.
- Reset asserted while in RESP → outputs 0 immediately; a later `mem_rsp_valid` is ignored; a new `start` runs cleanly.
